// File: rtl/sm_trace_buf.sv
// Execution-trace recorder for the schoolMIPS core: a circular buffer of
// {cycle, pc, instr} samples with a PC-match trigger and a cycle timeout.
module sm_trace_buf #(
  parameter int DEPTH_LOG   = 5,
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int POST_TRIG   = 8,
  parameter int TIMEOUT     = 120
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   arm,
  input  logic                   trig_en,
  input  logic [PC_WIDTH-1:0]    trig_pc,
  input  logic [DEPTH_LOG-1:0]   rd_addr,
  output logic [PC_WIDTH-1:0]    rd_pc,
  output logic [INSTR_WIDTH-1:0] rd_instr,
  output logic [CNT_WIDTH-1:0]   rd_cycle,
  output logic [DEPTH_LOG:0]     fill,
  output logic [1:0]             state,
  output logic                   done,
  output logic                   halt_req,
  output logic [CNT_WIDTH-1:0]   cycle
);

  localparam int DEPTH   = 1 << DEPTH_LOG;
  localparam int ENTRY_W = CNT_WIDTH + PC_WIDTH + INSTR_WIDTH;
  localparam logic [DEPTH_LOG:0]   FULL      = (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [DEPTH_LOG-1:0] POST_INIT = DEPTH_LOG'(POST_TRIG);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT                  stateQ, stateNext;
  logic [DEPTH_LOG-1:0]   wrPtr;
  logic [DEPTH_LOG:0]     fillQ;
  logic [DEPTH_LOG-1:0]   postCnt, postNext;
  logic [CNT_WIDTH-1:0]   cycleQ;
  logic                   haltQ;
  logic                   doWrite, clearBuf, trigHit;
  logic [DEPTH_LOG-1:0]   physIdx;
  logic                   rdValid;
  logic [ENTRY_W-1:0]     mem [DEPTH];

  assign trigHit = trig_en && (pc == trig_pc);

  // Arm wins over everything; otherwise only enabled cycles in ARMED/POST record.
  always_comb begin
    stateNext = stateQ;
    postNext  = postCnt;
    doWrite   = 1'b0;
    clearBuf  = 1'b0;
    if (arm) begin
      stateNext = ARMED;
      clearBuf  = 1'b1;
    end else if (en) begin
      case (stateQ)
        ARMED: begin
          doWrite = 1'b1;
          if (trigHit) begin
            if (POST_TRIG == 0) begin
              stateNext = DONE;
            end else begin
              stateNext = POST;
              postNext  = POST_INIT;
            end
          end
        end
        POST: begin
          doWrite  = 1'b1;
          postNext = postCnt - 1'b1;
          if (postCnt == 1) begin
            stateNext = DONE;
          end
        end
        default: begin
          doWrite = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ  <= IDLE;
      postCnt <= '0;
      wrPtr   <= '0;
      fillQ   <= '0;
    end else begin
      stateQ  <= stateNext;
      postCnt <= postNext;
      if (clearBuf) begin
        wrPtr <= '0;
        fillQ <= '0;
      end else if (doWrite) begin
        wrPtr <= wrPtr + 1'b1;
        if (fillQ != FULL) begin
          fillQ <= fillQ + 1'b1;
        end
      end
    end
  end

  // Buffer RAM carries no reset so it can map onto block memory.
  always_ff @(posedge clk) begin
    if (rst_n && doWrite) begin
      mem[wrPtr] <= {cycleQ, pc, instr};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycleQ <= '0;
    end else if (en && (cycleQ != {CNT_WIDTH{1'b1}})) begin
      cycleQ <= cycleQ + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      haltQ <= 1'b0;
    end else if ((TIMEOUT != 0) && (cycleQ >= TIMEOUT_C)) begin
      haltQ <= 1'b1;
    end
  end

  // Index 0 maps to the oldest valid entry; the low bits of fill wrap mod DEPTH.
  assign physIdx = wrPtr - fillQ[DEPTH_LOG-1:0] + rd_addr;
  assign rdValid = ({1'b0, rd_addr} < fillQ);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cycle <= '0;
      rd_pc    <= '0;
      rd_instr <= '0;
    end else if (rdValid) begin
      {rd_cycle, rd_pc, rd_instr} <= mem[physIdx];
    end else begin
      rd_cycle <= '0;
      rd_pc    <= '0;
      rd_instr <= '0;
    end
  end

  assign fill     = fillQ;
  assign state    = stateQ;
  assign done     = (stateQ == DONE);
  assign halt_req = haltQ;
  assign cycle    = cycleQ;

endmodule

// File: tb/tb_sm_trace_buf.sv
// Directed self-checking bench for sm_trace_buf with default parameters
// (DEPTH=32, POST_TRIG=8, TIMEOUT=120).
module tb_sm_trace_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        arm;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic [4:0]  rd_addr;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;
  logic [15:0] rd_cycle;
  logic [5:0]  fill;
  logic [1:0]  state;
  logic        done;
  logic        halt_req;
  logic [15:0] cycle;

  int testsRun = 0;
  int testsFailed = 0;

  sm_trace_buf dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .pc       (pc),
    .instr    (instr),
    .arm      (arm),
    .trig_en  (trig_en),
    .trig_pc  (trig_pc),
    .rd_addr  (rd_addr),
    .rd_pc    (rd_pc),
    .rd_instr (rd_instr),
    .rd_cycle (rd_cycle),
    .fill     (fill),
    .state    (state),
    .done     (done),
    .halt_req (halt_req),
    .cycle    (cycle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
    testsRun++;
    if (got !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expected);
    end
  endtask

  // One clock with the given enable, PC and arm; instr is derived from pc.
  task automatic applyStimulus(input logic e, input logic [31:0] p, input logic a);
    en    = e;
    pc    = p;
    instr = {16'hA5A5, p[15:0]};
    arm   = a;
    tick();
  endtask

  task automatic readEntry(input logic [4:0] addr);
    en      = 1'b0;
    arm     = 1'b0;
    rd_addr = addr;
    tick();
  endtask

  task automatic doReset();
    rst_n   = 1'b0;
    en      = 1'b0;
    arm     = 1'b0;
    trig_en = 1'b0;
    trig_pc = '0;
    rd_addr = '0;
    pc      = '0;
    instr   = '0;
    repeat (4) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    doReset();
    checkOutput("rst_state", state, 0);
    checkOutput("rst_fill", fill, 0);
    checkOutput("rst_cycle", cycle, 0);
    checkOutput("rst_halt", halt_req, 0);
    checkOutput("rst_rdpc", rd_pc, 0);
    checkOutput("rst_done", done, 0);

    // Partial fill: 10 samples, pc = 0..9
    doReset();
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("arm_state", state, 1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'(i), 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("p10_fill", fill, 10);
    checkOutput("p10_state", state, 1);
    checkOutput("p10_cycle", cycle, 10);
    readEntry(5'd0);
    checkOutput("p10_rd0_pc", rd_pc, 0);
    checkOutput("p10_rd0_instr", rd_instr, 32'hA5A5_0000);
    readEntry(5'd9);
    checkOutput("p10_rd9_pc", rd_pc, 9);
    checkOutput("p10_rd9_cycle", rd_cycle, 9);
    checkOutput("p10_rd9_instr", rd_instr, 32'hA5A5_0009);
    readEntry(5'd10);
    checkOutput("p10_rd10_pc", rd_pc, 0);

    // Wrap: 40 samples into 32 entries, oldest surviving pc is 8
    doReset();
    applyStimulus(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 32'(i), 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("wrap_fill", fill, 32);
    readEntry(5'd0);
    checkOutput("wrap_rd0_pc", rd_pc, 8);
    checkOutput("wrap_rd0_cycle", rd_cycle, 8);
    readEntry(5'd31);
    checkOutput("wrap_rd31_pc", rd_pc, 39);

    // Trigger at pc=20, 8 post-trigger entries, capture freezes after pc=28
    doReset();
    trig_en = 1'b1;
    trig_pc = 32'd20;
    applyStimulus(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 35; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0);
      if (i == 19) checkOutput("trig_pre_state", state, 1);
      if (i == 20) checkOutput("trig_hit_state", state, 2);
      if (i == 27) checkOutput("trig_post27_state", state, 2);
      if (i == 28) checkOutput("trig_done_state", state, 3);
    end
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("trig_fill", fill, 29);
    checkOutput("trig_done", done, 1);
    checkOutput("trig_cycle", cycle, 35);
    readEntry(5'd28);
    checkOutput("trig_rd28_pc", rd_pc, 28);
    readEntry(5'd20);
    checkOutput("trig_rd20_pc", rd_pc, 20);
    readEntry(5'd29);
    checkOutput("trig_rd29_pc", rd_pc, 0);

    // Timeout with en toggling; halt_req is sticky across arm
    doReset();
    for (int i = 0; i < 119; i++) begin
      applyStimulus(1'b1, 32'd0, 1'b0);
      applyStimulus(1'b0, 32'd0, 1'b0);
    end
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("to_cycle119", cycle, 119);
    checkOutput("to_halt_before", halt_req, 0);
    applyStimulus(1'b1, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("to_cycle120", cycle, 120);
    checkOutput("to_halt_after", halt_req, 1);
    applyStimulus(1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("to_halt_sticky", halt_req, 1);
    checkOutput("to_arm_state", state, 1);

    // Arm beats a PC match while in POST
    doReset();
    trig_en = 1'b1;
    trig_pc = 32'd5;
    applyStimulus(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'(i), 1'b0);
    checkOutput("rearm_pre_state", state, 2);
    checkOutput("rearm_pre_fill", fill, 8);
    applyStimulus(1'b1, 32'd5, 1'b1);
    checkOutput("rearm_state", state, 1);
    checkOutput("rearm_fill", fill, 0);
    readEntry(5'd0);
    checkOutput("rearm_rd0_empty", rd_pc, 0);
    applyStimulus(1'b1, 32'd100, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("rearm_fill1", fill, 1);
    readEntry(5'd0);
    checkOutput("rearm_rd0_pc", rd_pc, 100);

    // Reset in the middle of POST aborts the capture
    doReset();
    trig_en = 1'b1;
    trig_pc = 32'd5;
    applyStimulus(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'(i), 1'b0);
    checkOutput("rstpost_pre_state", state, 2);
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'd7, 1'b0);
    rst_n = 1'b1;
    checkOutput("rstpost_state", state, 0);
    checkOutput("rstpost_fill", fill, 0);
    checkOutput("rstpost_cycle", cycle, 0);
    checkOutput("rstpost_rdpc", rd_pc, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
